inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC loaded on reset.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  SHALL be a synchronous, active-low reset.
REQ-004 imem_req  out  1  SHALL request the instruction word at imem_addr.
REQ-005 imem_addr  out  32  SHALL be the current PC.
REQ-006 imem_rvalid  in  1  SHALL mark that imem_rdata holds the requested word.
REQ-007 imem_rdata  in  32  SHALL be the instruction word from memory.
REQ-008 inst  out  32  SHALL be the held instruction presented to the decoder.
REQ-009 inst_valid  out  1  SHALL mark that inst and pc are valid.
REQ-010 pc  out  32  SHALL be the address of inst.
REQ-011 inst_ready  in  1  SHALL mark that downstream retires inst this cycle.
REQ-012 pc_sel  in  2  SHALL select the next PC: 00 = PC+4, 01 = target (branch/JAL), 10 = target with bit0 cleared (JALR), 11 = PC+4.
REQ-013 target  in  32  SHALL be the computed jump or branch address.
REQ-014 halt  in  1  SHALL request a fetch stop (ECALL/EBREAK).
REQ-015 fault  out  1  SHALL flag a misaligned fetch target.
REQ-016 fault_pc  out  32  SHALL hold the offending target address.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT, VALID, HALT and FAULT.
REQ-018 IDLE SHALL last exactly one cycle and then go to REQ.
REQ-019 REQ SHALL assert imem_req for exactly one cycle and then go to WAIT.
REQ-020 WAIT SHALL hold until imem_rvalid = 1, then capture imem_rdata into inst and go to VALID; imem_rvalid outside WAIT SHALL be ignored.
REQ-021 VALID SHALL assert inst_valid and hold inst and pc stable until inst_ready = 1.
REQ-022 On inst_valid && inst_ready, pc_sel and target SHALL be sampled, the PC SHALL update, and the FSM SHALL go to REQ; minimum throughput is 1 instruction per 3 cycles.
REQ-023 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 If halt = 1 together with inst_ready in VALID, the instruction SHALL retire and the FSM SHALL go to HALT; halt in any other cycle SHALL be ignored.
REQ-025 HALT and FAULT SHALL be exited only by reset, with imem_req = 0 and inst_valid = 0.
REQ-026 A selected next PC with bits[1:0] != 0 SHALL be handled per REQ-030/031.

Reset
REQ-027 While rst_n = 0 at a clock edge: pc = RESET_PC, state = IDLE, inst = 32'h0000_0013 (NOP), inst_valid = 0, imem_req = 0, fault = 0, fault_pc = 0.
REQ-028 Reset asserted mid-transaction SHALL abandon the access; a late imem_rvalid SHALL be ignored.

Configuration
REQ-029 The macro IF_MISALIGN_TRAP_EN SHALL select misaligned-target handling.
REQ-030 With IF_MISALIGN_TRAP_EN defined: go to FAULT, set fault = 1 and fault_pc = offending target, leave pc unchanged, issue no request.
REQ-031 Without IF_MISALIGN_TRAP_EN: force next-PC bits[1:0] to 00 and keep fault and fault_pc at 0.

Structure
REQ-032 Package rv32i_pkg SHALL hold the pc_sel encodings, the FSM state enum, and the NOP constant 32'h0000_0013.
REQ-033 Next-PC selection SHALL be a combinational sub-module pc_next_sel (inputs pc, pc_sel, target; outputs next_pc, misaligned).

Verification
REQ-034 Reset release, RESET_PC = 0, memory rvalid one cycle after req, ready always 1 -> imem_addr sequence 0, 4, 8; inst_valid high every third cycle.
REQ-035 inst_ready held 0 for 5 cycles in VALID -> inst, pc and inst_valid stable; no imem_req issued.
REQ-036 pc = 32'h100, pc_sel = 10, target = 32'h205 -> next imem_addr = 32'h204.
REQ-037 pc = 32'hFFFF_FFFC, pc_sel = 00 -> next imem_addr = 32'h0000_0000.
REQ-038 pc_sel = 01, target = 32'h102 -> with macro defined: fault = 1, fault_pc = 32'h102, no imem_req; without macro: imem_addr = 32'h100.
REQ-039 halt = 1 with inst_ready = 1 -> FSM in HALT, no further imem_req; rst_n pulsed low in WAIT then rvalid arrives -> ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I fetch stage: pc_sel codes, fetch FSM states and the NOP word.
package rv32i_pkg;

    localparam logic [1:0] PcSelPlus4    = 2'b00;
    localparam logic [1:0] PcSelTarget   = 2'b01;
    localparam logic [1:0] PcSelJalr     = 2'b10;
    localparam logic [1:0] PcSelPlus4Alt = 2'b11;

    localparam logic [31:0] Nop = 32'h0000_0013;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StValid,
        StHalt,
        StFault
    } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux; flags a selected PC that is not word aligned.
module pc_next_sel
    import rv32i_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    always_comb begin
        next_pc = pc + 32'd4;
        case (pc_sel)
            PcSelTarget: next_pc = target;
            PcSelJalr:   next_pc = {target[31:1], 1'b0};
            default:     next_pc = pc + 32'd4;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding request, holds the word until the decoder retires it.
// Define IF_MISALIGN_TRAP_EN to trap on misaligned targets instead of truncating them.
module inst_fetch
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    input  logic        inst_ready,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] target,
    input  logic        halt,
    output logic        fault,
    output logic [31:0] fault_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic         fault_q, fault_d;
    logic [31:0]  fault_pc_q, fault_pc_d;
    logic [31:0]  next_pc;
    logic         misaligned;

    pc_next_sel u_pc_next_sel (
        .pc         (pc_q),
        .pc_sel     (pc_sel),
        .target     (target),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

`ifndef IF_MISALIGN_TRAP_EN
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        unique case (state_q)
            StIdle: state_d = StReq;
            StReq:  state_d = StWait;
            StWait: begin
                if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    state_d = StValid;
                end
            end
            StValid: begin
                if (inst_ready) begin
                    if (halt) begin
                        // Retire and stop; the PC stays on the halting instruction.
                        state_d = StHalt;
`ifdef IF_MISALIGN_TRAP_EN
                    end else if (misaligned) begin
                        fault_d    = 1'b1;
                        fault_pc_d = target;
                        state_d    = StFault;
`endif
                    end else begin
                        pc_d    = next_pc & ~32'h3;
                        state_d = StReq;
                    end
                end
            end
            StHalt:  state_d = StHalt;
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            inst_q     <= Nop;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign imem_req   = (state_q == StReq);
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = (state_q == StValid);
    assign pc         = pc_q;
    assign fault      = fault_q;
    assign fault_pc   = fault_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed, table-driven bench for inst_fetch; honours IF_MISALIGN_TRAP_EN like the RTL.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic        inst_ready;
    logic [1:0]  pc_sel;
    logic [31:0] target;
    logic        halt;
    logic        fault;
    logic [31:0] fault_pc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .pc          (pc),
        .inst_ready  (inst_ready),
        .pc_sel      (pc_sel),
        .target      (target),
        .halt        (halt),
        .fault       (fault),
        .fault_pc    (fault_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;  // expected fetch address of this transaction
        logic [1:0]  sel;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        for (int i = 0; i < 10 && imem_req !== 1'b1; i++) step();
        chk("req_seen", {31'b0, imem_req}, 32'd1);
    endtask

    // Fetch one word with rvalid in the cycle after req; ends sampling in VALID.
    task automatic fetch(input logic [31:0] exp_addr);
        wait_req();
        chk("imem_addr", imem_addr, exp_addr);
        step();
        chk("req_one_cycle", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(exp_addr);
        step();
        imem_rvalid = 1'b0;
        chk("inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("inst", inst, mem_word(exp_addr));
        chk("pc", pc, exp_addr);
    endtask

    task automatic retire(input logic [1:0] s, input logic [31:0] t, input logic h);
        inst_ready = 1'b1;
        pc_sel     = s;
        target     = t;
        halt       = h;
        step();
        inst_ready = 1'b0;
        halt       = 1'b0;
    endtask

    initial begin
        int last_valid;
        logic [31:0] held_inst;

        vecs[0] = '{32'h0000_0000, 2'b00, 32'h0};
        vecs[1] = '{32'h0000_0004, 2'b00, 32'h0};
        vecs[2] = '{32'h0000_0008, 2'b01, 32'h0000_0100};
        vecs[3] = '{32'h0000_0100, 2'b10, 32'h0000_0205};
        vecs[4] = '{32'h0000_0204, 2'b11, 32'hDEAD_0000};
        vecs[5] = '{32'h0000_0208, 2'b01, 32'hFFFF_FFFC};
        vecs[6] = '{32'hFFFF_FFFC, 2'b00, 32'h0};
        vecs[7] = '{32'h0000_0000, 2'b10, 32'h0000_0031};
        vecs[8] = '{32'h0000_0030, 2'b01, 32'h0000_0100};

        rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        inst_ready = 1'b0; pc_sel = 2'b00; target = 32'h0; halt = 1'b0;
        step(); step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        rst_n = 1'b1;

        // Back-to-back fetches with the decoder always ready: one VALID every 3 cycles.
        last_valid = 0;
        for (int i = 0; i < 9; i++) begin
            fetch(vecs[i].addr);
            if (i > 0) chk("cadence", cyc - last_valid, 32'd3);
            last_valid = cyc;
            retire(vecs[i].sel, vecs[i].tgt, 1'b0);
        end

        // Stall in VALID for 5 cycles; stray rvalid and halt must be ignored.
        fetch(32'h0000_0100);
        held_inst = inst;
        for (int i = 0; i < 5; i++) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBAD0_0000 + i;
            halt        = 1'b1;
            step();
            chk("stall_valid", {31'b0, inst_valid}, 32'd1);
            chk("stall_inst", inst, held_inst);
            chk("stall_pc", pc, 32'h0000_0100);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
        end
        imem_rvalid = 1'b0;
        halt = 1'b0;

        retire(2'b01, 32'h0000_0102, 1'b0);
`ifdef IF_MISALIGN_TRAP_EN
        chk("mis_fault", {31'b0, fault}, 32'd1);
        chk("mis_fault_pc", fault_pc, 32'h0000_0102);
        chk("mis_pc_kept", pc, 32'h0000_0100);
        for (int i = 0; i < 4; i++) begin
            chk("mis_no_req", {31'b0, imem_req}, 32'd0);
            chk("mis_no_valid", {31'b0, inst_valid}, 32'd0);
            step();
        end
`else
        chk("mis_req", {31'b0, imem_req}, 32'd1);
        chk("mis_addr", imem_addr, 32'h0000_0100);
        chk("mis_fault", {31'b0, fault}, 32'd0);
        chk("mis_fault_pc", fault_pc, 32'h0);
`endif

        // Reset from wherever we are, then again in the middle of a WAIT.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst2_fault", {31'b0, fault}, 32'd0);
        chk("rst2_pc", pc, 32'h0);
        step();
        chk("rst2_req", {31'b0, imem_req}, 32'd1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_idle_req", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk("late_rvalid_inst", inst, 32'h0000_0013);
        chk("late_rvalid_valid", {31'b0, inst_valid}, 32'd0);
        fetch(32'h0000_0000);

        // Halt retires the instruction and stops fetching for good.
        retire(2'b00, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("halt_no_req", {31'b0, imem_req}, 32'd0);
            chk("halt_no_valid", {31'b0, inst_valid}, 32'd0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
